innings_scorekeeper: RTL

//  Ball-by-ball score producer for the T20 match datapath; sits upstream of score_comparator.

---
 rtl/innings_scorekeeper_if.sv | 9 +
 rtl/innings_scorekeeper.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/innings_scorekeeper_if.sv
// Delivery-event handshake between the ball-by-ball source and innings_scorekeeper.
interface innings_scorekeeper_if;
   logic       ev_valid;
   logic [3:0] ev_code;
   logic       ev_ready;

   modport master (output ev_valid, ev_code, input ev_ready);
   modport slave  (input ev_valid, ev_code, output ev_ready);
endinterface

// File: rtl/innings_scorekeeper.sv
// T20 ball-by-ball scorekeeper: counts runs/wickets/legal balls per team and
// sequences innings 1 -> break -> innings 2 -> done.
module innings_scorekeeper #(
   parameter int unsigned MAX_BALLS    = 120,
   parameter int unsigned MAX_WICKETS  = 10,
   parameter int unsigned BREAK_CYCLES = 4,
   parameter int unsigned CHASE_END    = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   innings_scorekeeper_if.slave  ev,
   output logic [7:0]            team1_runs,
   output logic [3:0]            team1_wickets,
   output logic [6:0]            team_1_ball,
   output logic [7:0]            team2_runs,
   output logic [3:0]            team2_wickets,
   output logic [6:0]            team_2_ball,
   output logic [7:0]            runs,
   output logic [3:0]            wickets,
   output logic [6:0]            balls,
   output logic                  innings,
   output logic                  innings_done,
   output logic                  match_done,
   output logic                  ev_err
);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_INN1  = 3'd1;
   localparam logic [2:0] S_BREAK = 3'd2;
   localparam logic [2:0] S_INN2  = 3'd3;
   localparam logic [2:0] S_DONE  = 3'd4;

   localparam int unsigned BW = (BREAK_CYCLES > 1) ? $clog2(BREAK_CYCLES) : 1;

   logic [2:0]    state;
   logic [BW-1:0] brk_cnt;
   logic          accept;
   logic          at_end;
   logic          bad_code;
   logic [8:0]    run_sum;
   logic [7:0]    nxt_runs;
   logic [3:0]    nxt_wk;
   logic [6:0]    nxt_balls;
   logic [6:0]    ball_inc;

   assign ev.ev_ready = (state == S_INN1) || (state == S_INN2);
   assign accept      = ev.ev_valid & ev.ev_ready;
   assign match_done  = (state == S_DONE);

   assign runs    = innings ? team2_runs    : team1_runs;
   assign wickets = innings ? team2_wickets : team1_wickets;
   assign balls   = innings ? team_2_ball   : team_1_ball;

   assign ball_inc = (balls >= 7'(MAX_BALLS)) ? balls : balls + 7'd1;

   always_comb begin
      run_sum   = {1'b0, runs};
      nxt_wk    = wickets;
      nxt_balls = balls;
      bad_code  = 1'b0;
      if (ev.ev_code <= 4'd6) begin
         run_sum   = {1'b0, runs} + {5'd0, ev.ev_code};
         nxt_balls = ball_inc;
      end else if (ev.ev_code == 4'd7) begin
         nxt_wk    = (wickets >= 4'(MAX_WICKETS)) ? wickets : wickets + 4'd1;
         nxt_balls = ball_inc;
      end else if (ev.ev_code <= 4'd9) begin
         run_sum   = {1'b0, runs} + 9'd1;
      end else begin
         bad_code  = 1'b1;
      end
      nxt_runs = run_sum[8] ? 8'hFF : run_sum[7:0];
      // End test uses post-commit values so the innings closes on the same edge.
      at_end = (nxt_wk == 4'(MAX_WICKETS)) || (nxt_balls == 7'(MAX_BALLS)) ||
               (innings && (CHASE_END != 0) && (nxt_runs > team1_runs));
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state         <= S_IDLE;
         brk_cnt       <= '0;
         team1_runs    <= '0;
         team1_wickets <= '0;
         team_1_ball   <= '0;
         team2_runs    <= '0;
         team2_wickets <= '0;
         team_2_ball   <= '0;
         innings       <= 1'b0;
         innings_done  <= 1'b0;
         ev_err        <= 1'b0;
      end else begin
         innings_done <= 1'b0;
         ev_err       <= 1'b0;
         case (state)
            S_IDLE, S_DONE: begin
               if (start) begin
                  state         <= S_INN1;
                  team1_runs    <= '0;
                  team1_wickets <= '0;
                  team_1_ball   <= '0;
                  team2_runs    <= '0;
                  team2_wickets <= '0;
                  team_2_ball   <= '0;
                  innings       <= 1'b0;
               end
            end
            S_INN1, S_INN2: begin
               if (accept) begin
                  ev_err <= bad_code;
                  if (innings) begin
                     team2_runs    <= nxt_runs;
                     team2_wickets <= nxt_wk;
                     team_2_ball   <= nxt_balls;
                  end else begin
                     team1_runs    <= nxt_runs;
                     team1_wickets <= nxt_wk;
                     team_1_ball   <= nxt_balls;
                  end
                  if (at_end) begin
                     innings_done <= 1'b1;
                     brk_cnt      <= '0;
                     state        <= (state == S_INN1) ? S_BREAK : S_DONE;
                  end
               end
            end
            S_BREAK: begin
               if (brk_cnt == BW'(BREAK_CYCLES - 1)) begin
                  state   <= S_INN2;
                  innings <= 1'b1;
               end else begin
                  brk_cnt <= brk_cnt + 1'b1;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule
